// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase enumeration for the intersection scheduler.
package traffic_pkg;
   typedef logic [2:0] ryg_t;

   localparam ryg_t RED    = 3'b100;
   localparam ryg_t YELLOW = 3'b010;
   localparam ryg_t GREEN  = 3'b001;

   typedef enum logic [2:0] {HG, HY, ARH, CG, CY, ARC, PW} phase_t;
endpackage

// File: rtl/phase_timer.sv
// Saturating down-counter that times each phase; done flags the last cycle of an interval.
module phase_timer #(
   parameter int            TW      = 4,
   parameter logic [TW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          done
);
   logic [TW-1:0] tmr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_reg <= RST_VAL;
      end else if (load) begin
         tmr_reg <= load_val;
      end else if (tmr_reg != '0) begin
         tmr_reg <= tmr_reg - 1'b1;
      end
   end

   assign done = (tmr_reg == '0);
endmodule

// File: rtl/traffic_sched.sv
// Two-road intersection phase scheduler with pedestrian crossing.
// Moore FSM; the timer is reloaded on every phase change.
module traffic_sched
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN  = 8,
   parameter int CGREEN_MAX = 6,
   parameter int YELLOW_T   = 3,
   parameter int ALLRED_T   = 1,
   parameter int WALK_T     = 5,
   parameter int TW         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       x,
   input  logic       ped_req,
   output logic [2:0] Hryg,
   output logic [2:0] Cryg,
   output logic       walk,
   output logic       ped_pending
);
   phase_t state_reg, state_next;
   logic   ped_pend_reg, ped_pend_next;
   logic   done;
   logic   load;
   logic [TW-1:0] load_val;

   function automatic logic [TW-1:0] dur_m1(input phase_t p);
      case (p)
         HG:       dur_m1 = TW'(GREEN_MIN - 1);
         HY, CY:   dur_m1 = TW'(YELLOW_T - 1);
         ARH, ARC: dur_m1 = TW'(ALLRED_T - 1);
         CG:       dur_m1 = TW'(CGREEN_MAX - 1);
         PW:       dur_m1 = TW'(WALK_T - 1);
         default:  dur_m1 = TW'(GREEN_MIN - 1);
      endcase
   endfunction

   phase_timer #(
      .TW      (TW),
      .RST_VAL (TW'(GREEN_MIN - 1))
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= HG;
         ped_pend_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ped_pend_reg <= ped_pend_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HG:  if (done && (x || ped_pend_reg)) state_next = HY;
         HY:  if (done) state_next = ARH;
         ARH: if (done) state_next = ped_pend_reg ? PW : CG;
         CG:  if (done || !x) state_next = CY;
         CY:  if (done) state_next = ARC;
         ARC: if (done) state_next = ped_pend_reg ? PW : HG;
         PW:  if (done) state_next = HG;
         default: state_next = HG;
      endcase
   end

   assign load     = (state_next != state_reg);
   assign load_val = dur_m1(state_next);

   // Entering the walk phase serves the request, so the clear outranks a same-cycle press.
   always_comb begin
      ped_pend_next = ped_pend_reg;
      if (state_next == PW && state_reg != PW) begin
         ped_pend_next = 1'b0;
      end else if (ped_req && state_reg != PW) begin
         ped_pend_next = 1'b1;
      end
   end

   always_comb begin
      Hryg = RED;
      Cryg = RED;
      walk = 1'b0;
      case (state_reg)
         HG:      Hryg = GREEN;
         HY:      Hryg = YELLOW;
         CG:      Cryg = GREEN;
         CY:      Cryg = YELLOW;
         PW:      walk = 1'b1;
         default: ;
      endcase
   end

   assign ped_pending = ped_pend_reg;
endmodule

// File: tb/tb_traffic_sched.sv
// Randomized and directed bench for traffic_sched against an elapsed-time phase model.
module tb_traffic_sched;
   localparam int P_HG = 0, P_HY = 1, P_ARH = 2, P_CG = 3, P_CY = 4, P_ARC = 5, P_PW = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       x = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] Hryg, Cryg;
   logic       walk, ped_pending;

   int checks = 0;
   int errors = 0;

   int m_phase = P_HG;
   int m_el = 0;
   bit m_pend = 1'b0;

   traffic_sched dut (
      .clk         (clk),
      .rst         (rst),
      .x           (x),
      .ped_req     (ped_req),
      .Hryg        (Hryg),
      .Cryg        (Cryg),
      .walk        (walk),
      .ped_pending (ped_pending)
   );

   always #5 clk = ~clk;

   function automatic int dur(input int p);
      case (p)
         P_HG:         return 8;
         P_HY, P_CY:   return 3;
         P_ARH, P_ARC: return 1;
         P_CG:         return 6;
         default:      return 5;
      endcase
   endfunction

   function automatic logic [6:0] lamps(input int p);
      case (p)
         P_HG:    return {3'b001, 3'b100, 1'b0};
         P_HY:    return {3'b010, 3'b100, 1'b0};
         P_CG:    return {3'b100, 3'b001, 1'b0};
         P_CY:    return {3'b100, 3'b010, 1'b0};
         P_PW:    return {3'b100, 3'b100, 1'b1};
         default: return {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   // Model: phase plus cycles spent in it; a phase ends once it has lasted its duration.
   task automatic model_edge();
      int  nxt;
      bit  fin;
      if (rst) begin
         m_phase = P_HG;
         m_el    = 0;
         m_pend  = 1'b0;
      end else begin
         fin = (m_el + 1 >= dur(m_phase));
         nxt = m_phase;
         case (m_phase)
            P_HG:  if (fin && (x || m_pend)) nxt = P_HY;
            P_HY:  if (fin) nxt = P_ARH;
            P_ARH: if (fin) nxt = m_pend ? P_PW : P_CG;
            P_CG:  if (fin || !x) nxt = P_CY;
            P_CY:  if (fin) nxt = P_ARC;
            P_ARC: if (fin) nxt = m_pend ? P_PW : P_HG;
            default: if (fin) nxt = P_HG;
         endcase
         if (nxt == P_PW && m_phase != P_PW) m_pend = 1'b0;
         else if (ped_req && m_phase != P_PW) m_pend = 1'b1;
         m_el    = (nxt == m_phase) ? m_el + 1 : 0;
         m_phase = nxt;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; x = 1'b0; ped_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         checks++;
         if ({Hryg, Cryg, walk, ped_pending} !== {lamps(P_HG), 1'b0}) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %b want %b", k, {Hryg, Cryg, walk, ped_pending}, {lamps(P_HG), 1'b0});
         end
         tick();
      end
      x = 1'b1;
      for (int k = 0; k < 40 && !(m_phase == P_CY && m_el == 1); k++) tick();
      checks++;
      if (!(m_phase == P_CY && m_el == 1) || {Hryg, Cryg, walk} !== lamps(P_CY)) begin
         errors++;
         $display("FAIL reset_reach_cy: got %b want %b", {Hryg, Cryg, walk}, lamps(P_CY));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({Hryg, Cryg, walk, ped_pending} !== {lamps(P_HG), 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_cy: got %b want %b", {Hryg, Cryg, walk, ped_pending}, {lamps(P_HG), 1'b0});
      end
      for (int k = 0; k < 9; k++) begin
         checks++;
         if ({Hryg, Cryg, walk} !== lamps(k < 8 ? P_HG : P_HY)) begin
            errors++;
            $display("FAIL reset_reload cycle %0d: got %b want %b", k, {Hryg, Cryg, walk}, lamps(k < 8 ? P_HG : P_HY));
         end
         tick();
      end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_country_max();
      int ep;
      do_reset();
      for (int k = 0; k < 26; k++) begin
         x = (k >= 2);
         if (k < 8) ep = P_HG;
         else if (k < 11) ep = P_HY;
         else if (k == 11) ep = P_ARH;
         else if (k < 18) ep = P_CG;
         else if (k < 21) ep = P_CY;
         else if (k == 21) ep = P_ARC;
         else ep = P_HG;
         checks++;
         if ({Hryg, Cryg, walk} !== lamps(ep)) begin
            errors++;
            $display("FAIL country_max cycle %0d: got %b want %b", k, {Hryg, Cryg, walk}, lamps(ep));
         end
         tick();
      end
      $display("test_country_max done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_country_early();
      int ep;
      do_reset();
      for (int k = 0; k < 22; k++) begin
         x = (k < 14);
         if (k < 8) ep = P_HG;
         else if (k < 11) ep = P_HY;
         else if (k == 11) ep = P_ARH;
         else if (k < 15) ep = P_CG;
         else if (k < 18) ep = P_CY;
         else if (k == 18) ep = P_ARC;
         else ep = P_HG;
         checks++;
         if ({Hryg, Cryg, walk} !== lamps(ep)) begin
            errors++;
            $display("FAIL country_early cycle %0d: got %b want %b", k, {Hryg, Cryg, walk}, lamps(ep));
         end
         tick();
      end
      $display("test_country_early done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_pedestrian();
      int   ep;
      logic epend;
      do_reset();
      for (int k = 0; k < 20; k++) begin
         x = 1'b0;
         ped_req = (k == 1);
         if (k < 8) ep = P_HG;
         else if (k < 11) ep = P_HY;
         else if (k == 11) ep = P_ARH;
         else if (k < 17) ep = P_PW;
         else ep = P_HG;
         epend = (k >= 2 && k < 12);
         checks++;
         if ({Hryg, Cryg, walk, ped_pending} !== {lamps(ep), epend}) begin
            errors++;
            $display("FAIL pedestrian cycle %0d: got %b want %b", k, {Hryg, Cryg, walk, ped_pending}, {lamps(ep), epend});
         end
         tick();
      end
      ped_req = 1'b0;
      $display("test_pedestrian done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_priority();
      int   ep;
      logic epend;
      do_reset();
      for (int k = 0; k < 32; k++) begin
         x = 1'b1;
         ped_req = (k == 0 || k == 13 || k == 15);
         if (k < 8) ep = P_HG;
         else if (k < 11) ep = P_HY;
         else if (k == 11) ep = P_ARH;
         else if (k < 17) ep = P_PW;
         else if (k < 25) ep = P_HG;
         else if (k < 28) ep = P_HY;
         else if (k == 28) ep = P_ARH;
         else ep = P_CG;
         epend = (k >= 1 && k < 12);
         checks++;
         if ({Hryg, Cryg, walk, ped_pending} !== {lamps(ep), epend}) begin
            errors++;
            $display("FAIL priority cycle %0d: got %b want %b", k, {Hryg, Cryg, walk, ped_pending}, {lamps(ep), epend});
         end
         tick();
      end
      ped_req = 1'b0;
      $display("test_priority done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random();
      logic [2:0] prev_h, prev_c;
      do_reset();
      prev_h = Hryg;
      prev_c = Cryg;
      for (int k = 0; k < 2000; k++) begin
         x = ($urandom_range(0, 9) < 6);
         ped_req = ($urandom_range(0, 29) == 0);
         checks++;
         if ({Hryg, Cryg, walk, ped_pending} !== {lamps(m_phase), m_pend}) begin
            errors++;
            $display("FAIL random_model cycle %0d: got %b want %b", k, {Hryg, Cryg, walk, ped_pending}, {lamps(m_phase), m_pend});
         end
         checks++;
         if ((Hryg !== 3'b100 && Cryg !== 3'b100) || (walk && (Hryg !== 3'b100 || Cryg !== 3'b100))) begin
            errors++;
            $display("FAIL random_safety cycle %0d: got H=%b C=%b walk=%b want at most one non-red road", k, Hryg, Cryg, walk);
         end
         if ((prev_h == 3'b010 && Hryg !== 3'b010) || (prev_c == 3'b010 && Cryg !== 3'b010)) begin
            checks++;
            if (Hryg !== 3'b100 || Cryg !== 3'b100) begin
               errors++;
               $display("FAIL random_allred cycle %0d: got H=%b C=%b want 100/100", k, Hryg, Cryg);
            end
         end
         prev_h = Hryg;
         prev_c = Cryg;
         tick();
      end
      x = 1'b0;
      ped_req = 1'b0;
      $display("test_random done: checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      test_reset();
      test_country_max();
      test_country_early();
      test_pedestrian();
      test_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
